// File: rtl/divided_pow2_stream_if.sv
// Byte-stream bundle for divided_pow2_stream: input beats in,
// divided beats and abort flag out.
interface divided_pow2_stream_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic [DATA_W-1:0] data_out;
  logic              data_valid_out;
  logic              frame_err;

  modport master (
    output data_in,
    output data_valid,
    input  data_out,
    input  data_valid_out,
    input  frame_err
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_out,
    output data_valid_out,
    output frame_err
  );
endinterface

// File: rtl/divided_pow2_stream.sv
// Packs BYTES beats into a word, divides by 2^SHIFT and
// re-emits the quotient MS beat first; flags short bursts.
module divided_pow2_stream #(
  parameter int DATA_W = 8,
  parameter int BYTES  = 2,
  parameter int SHIFT  = 2,
  parameter int ROUND  = 0,
  parameter int SIGNED = 0
) (
  input logic                 CLKin,
  input logic                 reset,
  divided_pow2_stream_if.slave bus
);
  localparam int W  = DATA_W * BYTES;
  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);
  localparam logic [W:0] RND =
    (ROUND != 0) ? ((W+1)'(1) << (SHIFT - 1)) : '0;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     idx;
  logic [W-1:0]      asm_q;
  logic [W-1:0]      sh_q;
  logic [DATA_W-1:0] dout_q;
  logic              dvo_q;
  logic              ferr_q;

  logic              done;
  logic [W-1:0]      word;
  logic [W:0]        ext;
  logic [W:0]        sum;
  logic signed [W:0] ssum;
  logic [W:0]        shd;
  logic [W-1:0]      quo;
  logic              unused_msb;

  assign done = bus.data_valid && (cnt == LAST);
  assign word = (asm_q << DATA_W) | W'(bus.data_in);

  // W+1 bits leaves headroom for the rounding add
  assign ext  = (SIGNED != 0) ? {word[W-1], word}
                              : {1'b0, word};
  assign sum  = ext + RND;
  assign ssum = sum;

  always_comb begin
    shd = '0;
    if (SIGNED != 0) shd = ssum >>> SHIFT;
    else             shd = sum >> SHIFT;
  end

  assign quo        = shd[W-1:0];
  assign unused_msb = shd[W];

  always_ff @(posedge CLKin or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      asm_q  <= '0;
      ferr_q <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      if (bus.data_valid) begin
        if (cnt == LAST) begin
          cnt   <= '0;
          asm_q <= '0;
        end else begin
          cnt   <= cnt + 1'b1;
          asm_q <= word;
        end
      end else begin
        if (cnt != '0) ferr_q <= 1'b1;
        cnt   <= '0;
        asm_q <= '0;
      end
    end
  end

  // A completing word always reloads; it can only land as
  // the previous emission finishes.
  always_ff @(posedge CLKin or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      sh_q   <= '0;
      dout_q <= '0;
      dvo_q  <= 1'b0;
    end else if (done) begin
      state  <= EMIT;
      idx    <= '0;
      dout_q <= quo[W-1 -: DATA_W];
      sh_q   <= quo << DATA_W;
      dvo_q  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          dout_q <= '0;
          dvo_q  <= 1'b0;
        end
        EMIT: begin
          if (idx == LAST) begin
            state  <= IDLE;
            dout_q <= '0;
            dvo_q  <= 1'b0;
          end else begin
            idx    <= idx + 1'b1;
            dout_q <= sh_q[W-1 -: DATA_W];
            sh_q   <= sh_q << DATA_W;
          end
        end
        default: begin
          state  <= IDLE;
          dout_q <= '0;
          dvo_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out       = dout_q;
  assign bus.data_valid_out = dvo_q;
  assign bus.frame_err      = ferr_q;
endmodule

// File: tb/tb_divided_pow2_stream.sv
// Bench for divided_pow2_stream: three configs (trunc, round,
// signed) fed the same beats, scoreboarded per instance.
module tb_divided_pow2_stream;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       dvalid = 1'b0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t q[3][$];
  int   fe[3][$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] dout[3];
  logic       dvo[3];
  logic       ferr[3];

  for (genvar g = 0; g < 3; g++) begin : gd
    divided_pow2_stream_if #(.DATA_W(8)) bus ();
    assign bus.data_in    = din;
    assign bus.data_valid = dvalid;
    assign dout[g] = bus.data_out;
    assign dvo[g]  = bus.data_valid_out;
    assign ferr[g] = bus.frame_err;

    divided_pow2_stream #(
      .DATA_W(8),
      .BYTES (2),
      .SHIFT (2),
      .ROUND (g == 1 ? 1 : 0),
      .SIGNED(g == 2 ? 1 : 0)
    ) dut (
      .CLKin(clk),
      .reset(rst_n),
      .bus  (bus.slave)
    );

    exp_t e;
    int   fc;
    always @(negedge clk) begin
      if (rst_n) begin
        n_cmp++;
        if (dvo[g]) begin
          if (q[g].size() == 0) begin
            n_bad++;
            $display("FAIL dut%0d extra beat: got %h at cyc %0d, need none",
                     g, dout[g], cyc);
          end else begin
            e = q[g].pop_front();
            if (dout[g] !== e.d || cyc != e.c) begin
              n_bad++;
              $display("FAIL dut%0d beat: got %h@%0d, need %h@%0d",
                       g, dout[g], cyc, e.d, e.c);
            end
          end
        end else if (dout[g] !== 8'h00) begin
          n_bad++;
          $display("FAIL dut%0d idle data: got %h, need 00",
                   g, dout[g]);
        end
        if (ferr[g]) begin
          n_cmp++;
          if (fe[g].size() == 0) begin
            n_bad++;
            $display("FAIL dut%0d frame_err: got pulse at %0d, need none",
                     g, cyc);
          end else begin
            fc = fe[g].pop_front();
            if (fc != cyc) begin
              n_bad++;
              $display("FAIL dut%0d frame_err: got cyc %0d, need %0d",
                       g, cyc, fc);
            end
          end
        end
      end
    end
  end

  function automatic void chk(string nm, logic [31:0] got,
                              logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, need %0h", nm, got, want);
    end
  endfunction

  task automatic send(input logic [15:0] w, input logic [15:0] ea,
                      input logic [15:0] eb, input logic [15:0] ec);
    logic [15:0] ex[3];
    ex = '{ea, eb, ec};
    @(negedge clk);
    dvalid = 1'b1;
    din    = w[15:8];
    @(negedge clk);
    din = w[7:0];
    for (int g = 0; g < 3; g++) begin
      q[g].push_back('{ex[g][15:8], cyc + 1});
      q[g].push_back('{ex[g][7:0], cyc + 2});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dvalid = 1'b0;
      din    = '0;
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s dout%0d", tag, g), 32'(dout[g]), 0);
      chk($sformatf("%s dvo%0d", tag, g), 32'(dvo[g]), 0);
      chk($sformatf("%s ferr%0d", tag, g), 32'(ferr[g]), 0);
    end
  endtask

  initial begin
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    send(16'h7575, 16'h1D5D, 16'h1D5D, 16'h1D5D); idle(3);
    send(16'h8175, 16'h205D, 16'h205D, 16'hE05D); idle(3);
    send(16'h4135, 16'h104D, 16'h104D, 16'h104D); idle(3);
    send(16'h0003, 16'h0000, 16'h0001, 16'h0000); idle(3);
    send(16'h0002, 16'h0000, 16'h0001, 16'h0000); idle(3);
    send(16'hFFFF, 16'h3FFF, 16'h4000, 16'hFFFF); idle(3);
    send(16'h7FFF, 16'h1FFF, 16'h2000, 16'h1FFF); idle(3);

    // aborted single-beat burst
    @(negedge clk);
    dvalid = 1'b1;
    din    = 8'h75;
    @(negedge clk);
    dvalid = 1'b0;
    din    = '0;
    for (int g = 0; g < 3; g++) fe[g].push_back(cyc + 1);
    idle(3);
    send(16'h7575, 16'h1D5D, 16'h1D5D, 16'h1D5D); idle(3);

    // continuous stream, six beats
    send(16'h7575, 16'h1D5D, 16'h1D5D, 16'h1D5D);
    send(16'h8175, 16'h205D, 16'h205D, 16'hE05D);
    send(16'h4135, 16'h104D, 16'h104D, 16'h104D);
    idle(4);

    // reset while the MS beat is on the outputs
    send(16'h8175, 16'h205D, 16'h205D, 16'hE05D);
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    dvalid = 1'b0;
    din    = '0;
    for (int g = 0; g < 3; g++) begin
      q[g].delete();
      fe[g].delete();
    end
    #1;
    chk_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(16'h4135, 16'h104D, 16'h104D, 16'h104D); idle(4);

    for (int g = 0; g < 3; g++) begin
      chk($sformatf("left beats dut%0d", g), q[g].size(), 0);
      chk($sformatf("left ferr dut%0d", g), fe[g].size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/divided_pow2_stream.md
# divided_pow2_stream

Parametrised successor to the fixed byte divide-by-4 stage. It packs BYTES consecutive valid input beats into one word and divides the word by 2^SHIFT, with selectable truncate or round-half-up and unsigned or signed arithmetic. It then streams the result back out as BYTES beats, MS byte first. It sits in the byte-stream datapath between the upstream producer (no backpressure) and downstream consumers. It also flags aborted (short) bursts.

## Interface
- DATA_W, 8, beat width in bits
- BYTES, 2, beats per word; word width W = DATA_W*BYTES; BYTES ≥ 1
- SHIFT, 2, divide by 2^SHIFT; legal range 1 ≤ SHIFT ≤ W-1
- ROUND, 0, 0 = truncate (floor), 1 = round-half-up (add 2^(SHIFT-1) before shift)
- SIGNED, 0, 0 = unsigned logical shift, 1 = two's-complement arithmetic shift

Ports:
- CLKin  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- data_in  in  DATA_W  input beat
- data_valid  in  1  data_in valid this cycle
- data_out  out  DATA_W  output beat
- data_valid_out  out  1  data_out valid this cycle
- frame_err  out  1  one-cycle pulse: burst ended before BYTES beats

## Operation
- Collector:
  - beat counter cnt (0..BYTES-1) and an assembly shift register
  - first beat of a word is the MS byte
  - each sampled valid beat shifts in and increments cnt
- Word completion:
  - on the beat with cnt == BYTES-1, form word = {assembled, data_in}
  - compute the quotient and load it into the output register; cnt returns to 0
- Arithmetic:
  - extend word to W+1 bits (zero-extend if SIGNED=0, sign-extend if SIGNED=1)
  - if ROUND=1, add 2^(SHIFT-1)
  - shift right by SHIFT (logical if unsigned, arithmetic if signed)
  - take the low W bits; no overflow is possible with the W+1-bit intermediate, so there is no saturation logic
- Emitter:
  - state EMIT with beat index; outputs the MS beat first, one beat per cycle for BYTES cycles
  - data_valid_out is high only during EMIT
  - when not valid, data_out holds 0
- Abort:
  - data_valid = 0 while cnt ≠ 0 discards the partial word and clears cnt to 0
  - frame_err pulses for exactly one cycle; no output is generated for that word
- Collector and emitter run concurrently; a new word may be collected while the previous one is emitted.
- Reset (async, any time): cnt = 0, assembly register = 0, emitter idle.
  - data_out = 0, data_valid_out = 0, frame_err = 0
  - any word in flight or in collection is dropped

## Timing
- Beats are sampled at the rising edge where data_valid = 1.
- Latency: if the last beat is sampled at edge k, the MS output beat is valid in the cycle after edge k. Beat i (0 = MS) is valid after edge k+i, so the final beat follows edge k+BYTES-1.
- All outputs are registered; no combinational path from inputs to outputs.
- Back-to-back words (continuous data_valid):
  - the next word completes at edge k+BYTES and reloads exactly as the previous emission ends
  - data_valid_out stays continuously high with no gap and no overlap
  - sustained throughput is 1 beat per cycle
- frame_err timing: asserted in the cycle after the edge that samples data_valid = 0 with cnt ≠ 0.
- Abort and emission together: if the abort occurs during an ongoing emission, the emission completes unaffected.
- BYTES = 1: every valid beat is a full word; frame_err never asserts.
- Reset deassertion: the first valid beat sampled is treated as the MS beat of a new word.

## Test plan
- Unsigned, truncate, default params:
  - bursts 0x75,0x75 → output beats 0x1D,0x5D
  - 0x81,0x75 → 0x20,0x5D
  - 0x41,0x35 → 0x10,0x4D
  - each output burst follows the last input beat by 1 cycle and is 2 cycles long
- Rounding, ROUND = 1:
  - input 0x00,0x03 → 0x00,0x01; the same input with ROUND = 0 → 0x00,0x00
  - input 0x00,0x02 → 0x00,0x01 (half rounds up)
  - input 0xFF,0xFF → 0x40,0x00
- Signed, SIGNED = 1, ROUND = 0:
  - input 0x81,0x75 → 0xE0,0x5D
  - input 0x7F,0xFF → 0x1F,0xFF
- Abort: single beat 0x75 then data_valid = 0
  - frame_err is high for exactly 1 cycle and data_valid_out stays 0
  - a following full burst 0x75,0x75 → 0x1D,0x5D
- Continuous stream: data_valid held high for 6 cycles with 0x75,0x75,0x81,0x75,0x41,0x35
  - data_valid_out is high for 6 contiguous cycles: 0x1D,0x5D,0x20,0x5D,0x10,0x4D
- Reset mid-operation:
  - assert reset asynchronously between edges during emission of the MS beat; all outputs go to 0 immediately
  - after release, 0x41,0x35 → 0x10,0x4D with no residue of the old word
